// File: rtl/sram_if_pkg.sv
// sram_if_pkg
// Shared geometry of the 1024x128b byte-strobed SRAM macro. The macro model and
// every controller that drives it take their widths from here, so they always agree
// on the address width, the data width and the strobe width.
//   SRAM_ADDR_W : word address width (1024 words)
//   SRAM_DATA_W : data width in bits; must be a multiple of 8
//   strb_width  : derives the byte-strobe width from a data width
package sram_if_pkg;

    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 128;

    // One strobe bit per byte lane.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    localparam int SRAM_STRB_W = strb_width(SRAM_DATA_W);

endpackage : sram_if_pkg

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
// Two-entry in-order register FIFO that holds SRAM read data until the consumer
// takes it. Entry "head" is always the oldest word and drives dout directly.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : remove the head; ignored while empty
//   dout       : head entry (0 after reset)
//   count      : number of valid entries, 0..2
//   full/empty : count == 2 / count == 0
module sram_rsp_fifo
    import sram_if_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;

    assign pop_ok = pop && (count_q != 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                if (count_q != 2'd2) begin
                    count_d = count_q + 2'd1;
                end
            end
            2'b01: begin
                // The second entry (if any) moves up to become the head.
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop keeps the count; the head leaves and
                // the incoming word lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule : sram_rsp_fifo

// File: rtl/sram_rw_port.sv
// sram_rw_port
// Valid/ready front end for the single-port byte-strobed SRAM macro. Requests
// drive the macro pins combinationally in the cycle they are accepted; read data
// arriving one cycle later is captured into a 2-entry response FIFO and returned
// in order.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready, ready may depend on valid-side signals
// (here req_ready depends on req_write and on rsp_ready, combinationally).
//
// Ports:
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb : request channel
//   rsp_valid/rsp_ready/rsp_rdata                              : read response channel
//   sram_cen/sram_wen/sram_addr/sram_wdata/sram_wstrb          : macro pins (to SRAM)
//   sram_rdata                                                  : macro read data
// DATA_W must be a multiple of 8.
module sram_rw_port
    import sram_if_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int STRB_W = strb_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [STRB_W-1:0] sram_wstrb,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic       fire;
    logic       pop;
    logic       rd_inflight_q, rd_inflight_d;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] outstanding;
    logic       read_credit_ok;

    assign fire = req_valid && req_ready;
    assign pop  = rsp_valid && rsp_ready;

    // Every read that has been accepted but not yet handed back holds a FIFO slot,
    // whether its data is still in the macro (rd_inflight) or already buffered.
    // A pop in this same cycle frees a slot early, which is what lets the port
    // stream one read per cycle with only two entries.
    assign outstanding    = {2'b00, rd_inflight_q} + {1'b0, fifo_count};
    assign read_credit_ok = (outstanding - {2'b00, pop}) < 3'd2;

    assign req_ready = rst_n && (req_write || read_credit_ok);

    // The macro presents new sram_rdata every cycle; only the cycle after an
    // accepted read carries data that belongs to us.
    assign rd_inflight_d = fire && !req_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
        end
    end

    sram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_inflight_q),
        .pop   (pop),
        .din   (sram_rdata),
        .dout  (rsp_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;

    assign sram_cen   = fire;
    assign sram_wen   = fire && req_write;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;
    assign sram_wstrb = req_write ? req_wstrb : '0;

    // The credit rule keeps a read from being accepted when its data could not
    // be stored, so a push into a full FIFO means the credit logic is broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_inflight_q && fifo_full));

endmodule : sram_rw_port

// File: tb/tb_sram_rw_port.sv
module tb_sram_rw_port;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rdata;
    logic         sram_cen;
    logic         sram_wen;
    logic [9:0]   sram_addr;
    logic [127:0] sram_wdata;
    logic [15:0]  sram_wstrb;
    logic [127:0] sram_rdata;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model: memory contents as the requester sees them, plus the
    // ordered list of read data still owed and the cycle each becomes visible.
    logic [127:0] ref_mem [1024];
    logic [127:0] exp_q [$];
    int           avail_q [$];

    // Behavioural SRAM macro, written only through the DUT pins.
    logic [127:0] sram_mem [1024];

    sram_rw_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wstrb (sram_wstrb),
        .sram_rdata (sram_rdata)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro: read port shows junk in every cycle without a read.
    always @(posedge clk) begin
        if (sram_cen && sram_wen) begin
            for (int b = 0; b < 16; b++) begin
                if (sram_wstrb[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
        if (sram_cen && !sram_wen) sram_rdata <= sram_mem[sram_addr];
        else sram_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, update the model.
    task automatic cycle(input bit v, input bit w, input logic [9:0] a,
                         input logic [127:0] d, input logic [15:0] s,
                         input bit rr, output bit acc);
        bit exp_valid, exp_pop, exp_ready, fire;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        rsp_ready = rr;
        #2;
        exp_valid = rst_n && (exp_q.size() > 0) && (avail_q[0] <= cyc);
        exp_pop   = exp_valid && rr;
        exp_ready = rst_n && (w || ((exp_q.size() - int'(exp_pop)) < 2));
        fire      = v && exp_ready;
        chk("req_ready", {127'b0, req_ready}, {127'b0, exp_ready});
        chk("rsp_valid", {127'b0, rsp_valid}, {127'b0, exp_valid});
        if (exp_valid) chk("rsp_rdata", rsp_rdata, exp_q[0]);
        chk("sram_cen", {127'b0, sram_cen}, {127'b0, fire});
        chk("sram_wen", {127'b0, sram_wen}, {127'b0, fire && w});
        chk("sram_wstrb", {112'b0, sram_wstrb}, {112'b0, (w ? s : 16'h0)});
        if (fire) chk("sram_addr", {118'b0, sram_addr}, {118'b0, a});
        if (fire && w) chk("sram_wdata", sram_wdata, d);
        if (exp_pop) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
        end
        if (fire) begin
            if (w) begin
                for (int b = 0; b < 16; b++) begin
                    if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                exp_q.push_back(ref_mem[a]);
                avail_q.push_back(cyc + 2);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        acc = fire;
    endtask

    task automatic wr(input logic [9:0] a, input logic [127:0] d, input logic [15:0] s, input bit rr);
        bit acc;
        cycle(1'b1, 1'b1, a, d, s, rr, acc);
    endtask

    task automatic rd(input logic [9:0] a, input bit rr);
        bit acc;
        cycle(1'b1, 1'b0, a, 128'h0, 16'h0, rr, acc);
    endtask

    task automatic idle(input bit rr, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 10'h0, 128'h0, 16'h0, rr, acc);
    endtask

    initial begin
        bit acc;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        // Reset held with a pending read request
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h3;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {127'b0, req_ready}, 128'h0);
        chk("rst_sram_cen", {127'b0, sram_cen}, 128'h0);
        chk("rst_rsp_valid", {127'b0, rsp_valid}, 128'h0);
        chk("rst_rsp_rdata", rsp_rdata, 128'h0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        idle(1'b1, 2);

        // Write then read the same address on the next cycle
        wr(10'h005, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 1'b1);
        rd(10'h005, 1'b1);
        idle(1'b1, 1);
        chk("wr_rd_valid", {127'b0, rsp_valid}, 128'h1);
        chk("wr_rd_data", rsp_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        idle(1'b1, 2);

        // Partial strobe
        wr(10'h010, {16{8'hAA}}, 16'hFFFF, 1'b1);
        wr(10'h010, {16{8'h55}}, 16'h0001, 1'b1);
        rd(10'h010, 1'b1);
        idle(1'b1, 1);
        chk("strb_data", rsp_rdata, {{15{8'hAA}}, 8'h55});
        idle(1'b1, 2);

        // Streaming: preload 0..7, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) wr(10'(i), 128'(i), 16'hFFFF, 1'b1);
        for (int i = 0; i < 8; i++) rd(10'(i), 1'b1);
        idle(1'b1, 4);

        // Backpressure: third read waits for the first pop, writes still flow
        rd(10'h001, 1'b0);
        rd(10'h002, 1'b0);
        cycle(1'b1, 1'b0, 10'h003, 128'h0, 16'h0, 1'b0, acc);
        idle(1'b0, 1);
        wr(10'h100, 128'hDEAD, 16'hFFFF, 1'b0);
        rd(10'h003, 1'b1);
        idle(1'b1, 4);

        // Reset with two reads buffered
        rd(10'h004, 1'b0);
        rd(10'h005, 1'b0);
        idle(1'b0, 2);
        req_valid = 1'b1;
        req_write = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midrst_rsp_valid", {127'b0, rsp_valid}, 128'h0);
        chk("midrst_rsp_rdata", rsp_rdata, 128'h0);
        chk("midrst_req_ready", {127'b0, req_ready}, 128'h0);
        chk("midrst_sram_cen", {127'b0, sram_cen}, 128'h0);
        exp_q.delete();
        avail_q.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        cyc++;
        idle(1'b1, 3);
        rd(10'h006, 1'b1);
        idle(1'b1, 3);

        // Randomized traffic over a small, fully initialised address window
        for (int i = 0; i < 16; i++)
            wr(10'(i), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  10'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom},
                  16'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        idle(1'b1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sram_rw_port
